entropy_pool: RTL and testbench

Entropy harvester that drives the single-bit `entropy` input of the on-chip LFSR PRNG instances. It synchronizes a bus of asynchronous noise pins, XOR-folds them to one raw bit per cycle, removes bias with a von Neumann extractor, buffers the extracted bits in a FIFO pool and releases them at a programmable rate. When the pool is empty it outputs 0, so each PRNG free-runs on its polynomial alone. A stuck-source health flag and a sticky overflow flag are exported for status readout.

---
 rtl/entropy_pool.sv | 215 +++++++++++++++++++++
 tb/tb_entropy_pool.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/entropy_pool.sv
`default_nettype none
// ============================================================================
// Module   : entropy_pool
// Brief    : Noise-pin synchronizer, von Neumann debiaser and FIFO bit pool
//            that meters harvested entropy into the LFSR PRNG entropy input.
// Revision : 1.0 - initial release
// ============================================================================
module entropy_pool #(
    parameter int NOISE_BITS  = 4,
    parameter int POOL_BITS   = 32,
    parameter int DRAIN_DIV   = 1,
    parameter int STUCK_LIMIT = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NOISE_BITS-1:0]          noise,
    output logic                           entropy,
    output logic                           fresh,
    output logic [$clog2(POOL_BITS+1)-1:0] level,
    output logic                           stuck,
    output logic                           overflow
);

    localparam int c_LEVEL_W = $clog2(POOL_BITS + 1);
    localparam int c_DIV_W   = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
    localparam int c_RUN_W   = $clog2(STUCK_LIMIT + 1);

    localparam logic [c_LEVEL_W-1:0] c_FULL      = c_LEVEL_W'(POOL_BITS);
    localparam logic [c_LEVEL_W-1:0] c_LEVEL_ONE = c_LEVEL_W'(1);
    localparam logic [c_DIV_W-1:0]   c_DIV_LAST  = c_DIV_W'(DRAIN_DIV - 1);
    localparam logic [c_DIV_W-1:0]   c_DIV_ONE   = c_DIV_W'(1);
    localparam logic [c_RUN_W-1:0]   c_RUN_MAX   = c_RUN_W'(STUCK_LIMIT);
    localparam logic [c_RUN_W-1:0]   c_RUN_ONE   = c_RUN_W'(1);

    generate
        if (NOISE_BITS < 1) begin : g_chk_noise_bits
            $error("entropy_pool: NOISE_BITS must be >= 1");
        end
        if (POOL_BITS < 2) begin : g_chk_pool_bits
            $error("entropy_pool: POOL_BITS must be >= 2");
        end
        if (DRAIN_DIV < 1) begin : g_chk_drain_div
            $error("entropy_pool: DRAIN_DIV must be >= 1");
        end
        if (STUCK_LIMIT < 2) begin : g_chk_stuck_limit
            $error("entropy_pool: STUCK_LIMIT must be >= 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        PH_FIRST  = 1'b0,
        PH_SECOND = 1'b1
    } phase_t;

    logic [NOISE_BITS-1:0] r_sync1;
    logic [NOISE_BITS-1:0] r_sync2;
    logic                  w_raw;

    phase_t                r_phase;
    logic                  r_first;
    logic                  r_vn_valid;
    logic                  r_vn_bit;

    logic [c_DIV_W-1:0]    r_div_cnt;
    logic [POOL_BITS-1:0]  r_pool;
    logic [POOL_BITS-1:0]  w_pool_next;
    logic [c_LEVEL_W-1:0]  r_level;
    logic [c_LEVEL_W-1:0]  w_level_next;
    logic [c_LEVEL_W-1:0]  w_wr_idx;
    logic                  w_slot;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    logic                  r_entropy;
    logic                  r_fresh;
    logic                  r_overflow;

    logic                  r_prev_r;
    logic                  w_raw_changed;
    logic [c_RUN_W-1:0]    r_run;
    logic [c_RUN_W-1:0]    w_run_next;
    logic                  r_stuck;

    // ------------------------------------------------------------------
    // Two-flop synchronizer per pin, folded to one raw bit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= noise;
            r_sync2 <= r_sync1;
        end
    end

    assign w_raw = ^r_sync2;

    // ------------------------------------------------------------------
    // Von Neumann extractor over non-overlapping raw pairs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= PH_FIRST;
            r_first    <= 1'b0;
            r_vn_valid <= 1'b0;
            r_vn_bit   <= 1'b0;
        end else begin
            case (r_phase)
                PH_FIRST: begin
                    r_first    <= w_raw;
                    r_vn_valid <= 1'b0;
                    r_phase    <= PH_SECOND;
                end
                PH_SECOND: begin
                    r_vn_valid <= (r_first != w_raw);
                    r_vn_bit   <= r_first;
                    r_phase    <= PH_FIRST;
                end
                default: begin
                    r_vn_valid <= 1'b0;
                    r_phase    <= PH_FIRST;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Drain slot and pool control
    // ------------------------------------------------------------------
    assign w_slot = (r_div_cnt == c_DIV_LAST);
    assign w_full = (r_level == c_FULL);
    assign w_pop  = w_slot && (r_level != '0);
    // A pop in the same cycle frees the slot a full pool needs for the push.
    assign w_push = r_vn_valid && (!w_full || w_pop);
    assign w_drop = r_vn_valid && w_full && !w_pop;

    assign w_wr_idx = r_level - c_LEVEL_W'(w_pop);

    always_comb begin
        w_pool_next = w_pop ? {1'b0, r_pool[POOL_BITS-1:1]} : r_pool;
        for (int i = 0; i < POOL_BITS; i++) begin
            if (w_push && (w_wr_idx == c_LEVEL_W'(i))) begin
                w_pool_next[i] = r_vn_bit;
            end
        end
    end

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + c_LEVEL_ONE;
        end else if (w_pop && !w_push) begin
            w_level_next = r_level - c_LEVEL_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt  <= '0;
            r_pool     <= '0;
            r_level    <= '0;
            r_entropy  <= 1'b0;
            r_fresh    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_div_cnt  <= w_slot ? '0 : (r_div_cnt + c_DIV_ONE);
            r_pool     <= w_pool_next;
            r_level    <= w_level_next;
            r_entropy  <= w_pop ? r_pool[0] : 1'b0;
            r_fresh    <= w_pop;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stuck-source health monitor on the raw bit
    // ------------------------------------------------------------------
    assign w_raw_changed = (w_raw != r_prev_r);

    always_comb begin
        if (w_raw_changed) begin
            w_run_next = c_RUN_ONE;
        end else if (r_run == c_RUN_MAX) begin
            w_run_next = r_run;
        end else begin
            w_run_next = r_run + c_RUN_ONE;
        end
    end

    // stuck follows the next run value so it drops on the very edge r changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_r <= 1'b0;
            r_run    <= c_RUN_ONE;
            r_stuck  <= 1'b0;
        end else begin
            r_prev_r <= w_raw;
            r_run    <= w_run_next;
            r_stuck  <= (w_run_next == c_RUN_MAX);
        end
    end

    assign entropy  = r_entropy;
    assign fresh    = r_fresh;
    assign level    = r_level;
    assign stuck    = r_stuck;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_entropy_pool.sv
`default_nettype none
// ============================================================================
// Module   : tb_entropy_pool
// Brief    : Self-checking bench; three pools (drain 1/8/16) share one noise bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_entropy_pool;

    localparam int NB    = 4;
    localparam int POOL  = 32;
    localparam int LIMIT = 64;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] noise = '0;
    logic [2:0]    ent;
    logic [2:0]    fr;
    logic [2:0]    st;
    logic [2:0]    ov;
    logic [5:0]    lv [3];

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    bit col_en   = 1'b0;
    bit got16 [$];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        entropy_pool #(
            .NOISE_BITS (NB),
            .POOL_BITS  (POOL),
            .DRAIN_DIV  ((gi == 0) ? 1 : ((gi == 1) ? 8 : 16)),
            .STUCK_LIMIT(LIMIT)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .noise   (noise),
            .entropy (ent[gi]),
            .fresh   (fr[gi]),
            .level   (lv[gi]),
            .stuck   (st[gi]),
            .overflow(ov[gi])
        );
    end

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 8 : 16);
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Reference model: bit pipeline, pair extractor, queue per pool.
    bit m_s1, m_s2, m_phase, m_first, m_vv, m_vb, m_prev, m_stuck;
    int m_run;
    int m_cnt [3];
    bit m_ent [3];
    bit m_fr  [3];
    bit m_ov  [3];
    bit mq    [3][$];

    initial begin : model
        bit raw, vv, vb, pop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = 0; m_s2 = 0; m_phase = 0; m_first = 0;
                m_vv = 0; m_vb = 0; m_prev = 0; m_stuck = 0; m_run = 1;
                for (int i = 0; i < 3; i++) begin
                    m_cnt[i] = 0; m_ent[i] = 0; m_fr[i] = 0; m_ov[i] = 0;
                    mq[i].delete();
                end
            end else begin
                raw = m_s2;
                vv  = m_vv;
                vb  = m_vb;
                if (!m_phase) begin
                    m_first = raw;
                    m_vv    = 0;
                end else begin
                    m_vv = (m_first != raw);
                    m_vb = m_first;
                end
                m_phase = !m_phase;
                for (int i = 0; i < 3; i++) begin
                    pop = (m_cnt[i] == div_of(i) - 1) && (mq[i].size() != 0);
                    m_fr[i] = pop;
                    if (pop) m_ent[i] = mq[i].pop_front();
                    else     m_ent[i] = 0;
                    if (vv) begin
                        if (mq[i].size() < POOL) mq[i].push_back(vb);
                        else                     m_ov[i] = 1;
                    end
                    m_cnt[i] = (m_cnt[i] + 1) % div_of(i);
                end
                if (raw != m_prev)     m_run = 1;
                else if (m_run < LIMIT) m_run++;
                m_stuck = (m_run == LIMIT);
                m_prev  = raw;
                m_s2    = m_s1;
                m_s1    = ^noise;
            end
        end
    end

    initial begin : scoreboard
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 3; i++) begin
                    check($sformatf("model_cmp[div%0d] {ent,fr,st,ov,lvl}", div_of(i)),
                          {ent[i], fr[i], st[i], ov[i], lv[i]},
                          {m_ent[i], m_fr[i], m_stuck, m_ov[i], 6'(mq[i].size())});
                end
            end
        end
    end

    initial begin : collector
        forever begin
            @(negedge clk);
            if (col_en && fr[2]) got16.push_back(ent[2]);
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit a;
        bit b;
        bit emits;
        bit exp_bit;
    } pair_t;

    initial begin : stim
        pair_t tbl [6];
        bit    exp_q [$];
        int    len, mode, fcount, max8, max16, found;

        tbl[0] = '{a: 1'b1, b: 1'b0, emits: 1'b1, exp_bit: 1'b1};
        tbl[1] = '{a: 1'b1, b: 1'b1, emits: 1'b0, exp_bit: 1'b0};
        tbl[2] = '{a: 1'b0, b: 1'b1, emits: 1'b1, exp_bit: 1'b0};
        tbl[3] = '{a: 1'b0, b: 1'b0, emits: 1'b0, exp_bit: 1'b0};
        tbl[4] = '{a: 1'b1, b: 1'b0, emits: 1'b1, exp_bit: 1'b1};
        tbl[5] = '{a: 1'b1, b: 1'b0, emits: 1'b1, exp_bit: 1'b1};
        for (int k = 0; k < 6; k++) if (tbl[k].emits) exp_q.push_back(tbl[k].exp_bit);

        // Reset held while noise toggles
        repeat (6) begin
            @(negedge clk);
            noise = NB'($urandom);
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("in_reset[%0d]", i), {ent[i], fr[i], lv[i], st[i], ov[i]}, 0);
        noise = '0;
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Constant zero noise: stuck after 64 equal raw samples (incl. reset value)
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            check($sformatf("const0_edge%0d", k), {ent[0], fr[0], lv[0], st[0], ov[0]},
                  {1'b0, 1'b0, 6'd0, (k >= 63), 1'b0});
        end
        noise = NB'(1);
        @(negedge clk); check("stuck_clear_e0", st[0], 1);
        @(negedge clk); check("stuck_clear_e1", st[0], 1);
        @(negedge clk); check("stuck_clear_e2", st[0], 0);

        // Toggle noise[0] each cycle, aligned so every pair is (1,0)
        if (m_phase) @(negedge clk);
        noise  = NB'(1);
        fcount = 0;
        max8   = 0;
        max16  = 0;
        for (int c = 1; c < 200; c++) begin
            @(negedge clk);
            if (fr[0]) check("div1_popped_bit", ent[0], 1);
            check("div1_lvl_le1_no_ovf", {(lv[0] <= 6'd1), ov[0]}, {1'b1, 1'b0});
            if (c >= 136 && fr[1]) fcount++;
            if (int'(lv[1]) > max8)  max8  = int'(lv[1]);
            if (int'(lv[2]) > max16) max16 = int'(lv[2]);
            noise[0] = ~noise[0];
        end
        check("div8_fresh_per_64", fcount, 8);
        check("div8_level_max", max8, POOL);
        check("div16_level_max", max16, POOL);
        check("div8_overflow", ov[1], 1);
        check("div1_overflow", ov[0], 0);

        // Drain toward level 10 then reset mid-run
        noise = '0;
        found = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (mq[1].size() == 10) begin
                found = 1;
                break;
            end
        end
        check("wait_level10", found, 1);
        check("pre_reset_div8", {lv[1], ov[1]}, {6'd10, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("mid_reset[%0d]", i), {lv[i], ov[i], fr[i], ent[i]}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("post_reset_quiet", {fr, ent, lv[0], lv[1], lv[2]}, 0);
        end

        // Ordering through the drain-16 pool
        got16.delete();
        col_en = 1'b1;
        if (m_phase) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            noise = NB'(tbl[k].a);
            @(negedge clk);
            noise = NB'(tbl[k].b);
            @(negedge clk);
        end
        noise = '0;
        for (int c = 0; c < 300 && got16.size() < exp_q.size(); c++) @(negedge clk);
        col_en = 1'b0;
        check("order_count", got16.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (k < got16.size()) check($sformatf("order_bit%0d", k), got16[k], exp_q[k]);

        // Randomized segments: per-cycle random, held values, toggling
        for (int seg = 0; seg < 40; seg++) begin
            len  = $urandom_range(5, 90);
            mode = $urandom_range(0, 2);
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                case (mode)
                    0:       noise = NB'($urandom);
                    1:       if (c == 0) noise = NB'($urandom);
                    default: noise[$urandom_range(0, NB-1)] ^= 1'b1;
                endcase
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
